// File: rtl/pbus_clock_group_reset_sequencer_pkg.sv
// Shared types and constants for the subsystem_pbus_0 clock-group
// reset sequencer: state encoding, output decode and counter sizing.
package pbus_clock_group_reset_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_HOLD,
        ST_RUN,
        ST_DRAIN,
        ST_ASSERT,
        ST_GATE
    } state_e;

    typedef struct packed {
        logic rst;
        logic clk_en;
        logic drain_req;
        logic busy;
    } ctl_t;

    localparam int DEF_SYNC_STAGES   = 3;
    localparam int DEF_HOLD_CYCLES   = 16;
    localparam int DEF_ASSERT_CYCLES = 2;
    localparam int DEF_GATE_CYCLES   = 4;
    localparam int DEF_DRAIN_TIMEOUT = 255;

    // Counter must reach every terminal count, including DRAIN_TIMEOUT.
    function automatic int cnt_width(input int hold, input int drain_to,
                                     input int asrt, input int gate);
        int m;
        m = hold;
        if (drain_to + 1 > m) m = drain_to + 1;
        if (asrt > m) m = asrt;
        if (gate > m) m = gate;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

    // Domain controls as seen while sitting in a given state.
    function automatic ctl_t decode(input state_e s);
        ctl_t c;
        c = '{rst: 1'b1, clk_en: 1'b0, drain_req: 1'b0, busy: 1'b1};
        unique case (s)
            ST_SYNC:   c = '{rst: 1'b1, clk_en: 1'b0, drain_req: 1'b0, busy: 1'b1};
            ST_HOLD:   c = '{rst: 1'b1, clk_en: 1'b1, drain_req: 1'b0, busy: 1'b1};
            ST_RUN:    c = '{rst: 1'b0, clk_en: 1'b1, drain_req: 1'b0, busy: 1'b0};
            ST_DRAIN:  c = '{rst: 1'b0, clk_en: 1'b1, drain_req: 1'b1, busy: 1'b1};
            ST_ASSERT: c = '{rst: 1'b1, clk_en: 1'b1, drain_req: 1'b0, busy: 1'b1};
            ST_GATE:   c = '{rst: 1'b1, clk_en: 1'b0, drain_req: 1'b0, busy: 1'b1};
            default:   c = '{rst: 1'b1, clk_en: 1'b0, drain_req: 1'b0, busy: 1'b1};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pbus_clock_group_reset_sequencer_if.sv
// Control/handshake bundle between the clock-group reset sequencer
// and the bus / aggregator side.
interface pbus_clock_group_reset_sequencer_if;

    logic sw_reset_req;
    logic drain_ack;
    logic auto_out_member_subsystem_pbus_0_reset;
    logic clock_en;
    logic drain_req;
    logic sw_reset_done;
    logic drain_timeout;
    logic busy;

    modport master (
        input  sw_reset_req,
        input  drain_ack,
        output auto_out_member_subsystem_pbus_0_reset,
        output clock_en,
        output drain_req,
        output sw_reset_done,
        output drain_timeout,
        output busy
    );

    modport slave (
        output sw_reset_req,
        output drain_ack,
        input  auto_out_member_subsystem_pbus_0_reset,
        input  clock_en,
        input  drain_req,
        input  sw_reset_done,
        input  drain_timeout,
        input  busy
    );

endinterface

// File: rtl/pbus_clock_group_reset_sequencer_reset_sync_chain.sv
// Reset-deassert synchroniser: asserts immediately, releases after
// STAGES clock edges. Shared by the clock-group sequencers.
module pbus_clock_group_reset_sequencer_reset_sync_chain
    import pbus_clock_group_reset_sequencer_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES
) (
    input  logic clock,
    input  logic reset,
    output logic sync_out
);

    logic [STAGES-1:0] chain;

    // Any reset pulse, however short, reloads every stage with 1.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) chain <= '1;
        else       chain <= {chain[STAGES-2:0], 1'b0};
    end

    assign sync_out = chain[STAGES-1];

endmodule

// File: rtl/pbus_clock_group_reset_sequencer.sv
// Reset and clock-gate sequencer for the subsystem_pbus_0 clock group,
// including the software-requested drain / reset / gate sequence.
module pbus_clock_group_reset_sequencer
    import pbus_clock_group_reset_sequencer_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int ASSERT_CYCLES = DEF_ASSERT_CYCLES,
    parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
    parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
    input  logic clock,
    input  logic reset,
    pbus_clock_group_reset_sequencer_if.master bus
);

    localparam int CW = cnt_width(HOLD_CYCLES, DRAIN_TIMEOUT,
                                  ASSERT_CYCLES, GATE_CYCLES);

    localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ASSERT_LAST = CW'(ASSERT_CYCLES - 1);
    localparam logic [CW-1:0] GATE_LAST   = CW'(GATE_CYCLES - 1);
    localparam logic [CW-1:0] DRAIN_LAST  = CW'(DRAIN_TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX     = '1;

    logic          sync_out;
    state_e        state;
    state_e        nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          sw_seq;
    logic          sw_seq_nxt;
    logic          set_tmo;
    logic          done_nxt;
    ctl_t          ctl_nxt;

    logic rst_q;
    logic en_q;
    logic dreq_q;
    logic busy_q;
    logic done_q;
    logic tmo_q;

    pbus_clock_group_reset_sequencer_reset_sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock    (clock),
        .reset    (reset),
        .sync_out (sync_out)
    );

    // Next-state, counter and event decode for the sequencer.
    always_comb begin
        nxt        = state;
        cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
        sw_seq_nxt = sw_seq;
        set_tmo    = 1'b0;
        done_nxt   = 1'b0;
        unique case (state)
            ST_SYNC: begin
                cnt_nxt = '0;
                if (!sync_out) nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (cnt == HOLD_LAST) begin
                    nxt        = ST_RUN;
                    cnt_nxt    = '0;
                    done_nxt   = sw_seq;
                    sw_seq_nxt = 1'b0;
                end
            end
            ST_RUN: begin
                cnt_nxt = '0;
                if (bus.sw_reset_req) begin
                    nxt        = ST_DRAIN;
                    sw_seq_nxt = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (bus.drain_ack) begin
                    nxt     = ST_ASSERT;
                    cnt_nxt = '0;
                end else if (cnt == DRAIN_LAST) begin
                    nxt     = ST_ASSERT;
                    cnt_nxt = '0;
                    set_tmo = 1'b1;
                end
            end
            ST_ASSERT: begin
                if (cnt == ASSERT_LAST) begin
                    nxt     = ST_GATE;
                    cnt_nxt = '0;
                end
            end
            ST_GATE: begin
                if (cnt == GATE_LAST) begin
                    nxt     = ST_HOLD;
                    cnt_nxt = '0;
                end
            end
            default: begin
                nxt     = ST_SYNC;
                cnt_nxt = '0;
            end
        endcase
        ctl_nxt = decode(nxt);
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_SYNC;
            cnt    <= '0;
            sw_seq <= 1'b0;
            rst_q  <= 1'b1;
            en_q   <= 1'b0;
            dreq_q <= 1'b0;
            busy_q <= 1'b1;
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
        end else begin
            state  <= nxt;
            cnt    <= cnt_nxt;
            sw_seq <= sw_seq_nxt;
            rst_q  <= ctl_nxt.rst;
            en_q   <= ctl_nxt.clk_en;
            dreq_q <= ctl_nxt.drain_req;
            busy_q <= ctl_nxt.busy;
            done_q <= done_nxt;
            tmo_q  <= tmo_q | set_tmo;
        end
    end

    assign bus.auto_out_member_subsystem_pbus_0_reset = rst_q;
    assign bus.clock_en      = en_q;
    assign bus.drain_req     = dreq_q;
    assign bus.busy          = busy_q;
    assign bus.sw_reset_done = done_q;
    assign bus.drain_timeout = tmo_q;

endmodule

// File: tb/tb_pbus_clock_group_reset_sequencer.sv
// Scoreboard bench for the pbus clock-group reset sequencer: directed
// stimulus queues expected output snapshots, a monitor compares them.
module tb_pbus_clock_group_reset_sequencer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    pbus_clock_group_reset_sequencer_if bus ();

    pbus_clock_group_reset_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Edge counter; value N at a negedge means edge N has just happened.
    always @(posedge clock) cyc <= cyc + 1;

    // {reset, clock_en, drain_req, sw_reset_done, drain_timeout, busy}
    logic [5:0] obs;
    assign obs = {bus.auto_out_member_subsystem_pbus_0_reset, bus.clock_en,
                  bus.drain_req, bus.sw_reset_done, bus.drain_timeout,
                  bus.busy};

    typedef struct {
        int         at;
        logic [5:0] v;
        string      name;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic push(input int at, input logic [5:0] v, input string name);
        exp_t e;
        e.at = at;
        e.v = v;
        e.name = name;
        sbq.push_back(e);
    endtask

    task automatic at_neg(input int e);
        while (cyc < e) @(negedge clock);
    endtask

    // Monitor: compare every expectation due at this sample point.
    always @(negedge clock) begin
        exp_t e;
        while (sbq.size() > 0 && sbq[0].at <= cyc) begin
            e = sbq.pop_front();
            n_checks++;
            if (e.at < cyc) begin
                n_fail++;
                $display("FAIL %s: sample for edge %0d missed (now %0d)",
                         e.name, e.at, cyc);
            end else if (obs !== e.v) begin
                n_fail++;
                $display("FAIL %s: edge %0d got %b expected %b",
                         e.name, cyc, obs, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    int b;
    int k;
    int m;

    initial begin
        bus.sw_reset_req = 1'b0;
        bus.drain_ack    = 1'b0;
        reset            = 1'b1;

        // Power-on: release before edge 1 (edge n is cyc b+n).
        push(1, 6'b100001, "por_reset_held");
        at_neg(2);
        b = 2;
        push(b + 3,  6'b100001, "por_sync");
        push(b + 4,  6'b110001, "por_hold");
        push(b + 19, 6'b110001, "por_hold_end");
        push(b + 20, 6'b010000, "por_run");
        push(b + 21, 6'b010000, "por_no_done");
        reset = 1'b0;

        // Ack arrives at the same edge the drain counter hits 255.
        at_neg(b + 24);
        k = cyc + 1;
        push(k,       6'b011001, "col_drain");
        push(k + 255, 6'b011001, "col_drain_last");
        push(k + 256, 6'b110001, "col_assert_no_tmo");
        push(k + 277, 6'b110001, "col_hold_end");
        push(k + 278, 6'b010100, "col_run_done");
        push(k + 279, 6'b010000, "col_done_end");
        bus.sw_reset_req = 1'b1;
        at_neg(k);
        bus.sw_reset_req = 1'b0;
        at_neg(k + 255);
        bus.drain_ack = 1'b1;
        at_neg(k + 256);
        bus.drain_ack = 1'b0;

        // Drain ends by timeout; sticky flag survives into RUN.
        at_neg(k + 281);
        k = cyc + 1;
        push(k,       6'b011001, "tmo_drain");
        push(k + 255, 6'b011001, "tmo_drain_last");
        push(k + 256, 6'b110011, "tmo_assert");
        push(k + 258, 6'b100011, "tmo_gate");
        push(k + 262, 6'b110011, "tmo_hold");
        push(k + 278, 6'b010110, "tmo_run_done");
        push(k + 279, 6'b010010, "tmo_sticky");
        push(k + 290, 6'b010010, "tmo_sticky_late");
        bus.sw_reset_req = 1'b1;
        at_neg(k);
        bus.sw_reset_req = 1'b0;
        at_neg(k + 291);

        // Acked software reset, ignored request in HOLD, and a request
        // held across RUN re-entry.
        k = cyc + 1;
        push(k,      6'b011011, "sw_drain");
        push(k + 4,  6'b011011, "sw_drain_end");
        push(k + 5,  6'b110011, "sw_assert");
        push(k + 6,  6'b110011, "sw_assert_end");
        push(k + 7,  6'b100011, "sw_gate");
        push(k + 10, 6'b100011, "sw_gate_end");
        push(k + 11, 6'b110011, "sw_hold");
        push(k + 16, 6'b110011, "sw_req_in_hold");
        push(k + 17, 6'b110011, "sw_req_ignored");
        push(k + 26, 6'b110011, "sw_hold_end");
        push(k + 27, 6'b010110, "sw_run_done");
        push(k + 28, 6'b011011, "sw_retrigger");
        push(k + 29, 6'b011011, "sw_retrigger_drain");
        bus.sw_reset_req = 1'b1;
        at_neg(k);
        bus.sw_reset_req = 1'b0;
        at_neg(k + 4);
        bus.drain_ack = 1'b1;
        at_neg(k + 5);
        bus.drain_ack = 1'b0;
        at_neg(k + 15);
        bus.sw_reset_req = 1'b1;
        at_neg(k + 16);
        bus.sw_reset_req = 1'b0;
        at_neg(k + 25);
        bus.sw_reset_req = 1'b1;
        at_neg(k + 28);
        bus.sw_reset_req = 1'b0;

        // Short async reset between edges while in DRAIN.
        m = k + 30;
        at_neg(m - 1);
        push(m,      6'b100001, "ar_immediate");
        push(m + 3,  6'b100001, "ar_sync");
        push(m + 4,  6'b110001, "ar_hold");
        push(m + 19, 6'b110001, "ar_hold_end");
        push(m + 20, 6'b010000, "ar_run");
        push(m + 21, 6'b010000, "ar_no_done");
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        #1 reset = 1'b0;
        at_neg(m + 23);

        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL %s: never sampled (edge %0d)", e.name, e.at);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
